vid_timing_gen: RTL and testbench

//  Video timing generator: the transmitter of the vsync/hsync/de pixel-stream interface.

---
 rtl/vid_timing_gen.sv | 81 ++++++++
 tb/tb_vid_timing_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vid_timing_gen.sv
// rtl/vid_timing_gen.sv - raster timing generator with registered sync/de/coordinate outputs
// Outputs are decoded from the counter position before each enabled edge, so they lag h_cnt/v_cnt by one.
module vid_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             frame_vsync,
  output logic             frame_hsync,
  output logic             frame_de,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             de_d;
  logic             hs_d;
  logic             vs_d;

  always_comb begin
    de_d = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_d = (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
    // v_cnt only moves when h_cnt wraps, so vsync edges land on whole lines
    vs_d = (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_de    <= 1'b0;
      frame_hsync <= ~HS_POL;
      frame_vsync <= ~VS_POL;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
      frame_de    <= de_d;
      frame_hsync <= hs_d;
      frame_vsync <= vs_d;
      pix_x       <= de_d ? h_cnt : '0;
      pix_y       <= de_d ? v_cnt : '0;
      frame_start <= de_d && (h_cnt == '0) && (v_cnt == '0);
      line_start  <= de_d && (h_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb/tb_vid_timing_gen.sv - directed bench for vid_timing_gen on a 14x8 raster
// Inputs change and outputs are sampled on the falling edge.
module tb_vid_timing_gen;

  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             frame_vsync;
  logic             frame_hsync;
  logic             frame_de;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             frame_start;
  logic             line_start;

  int n_cmp = 0;
  int n_err = 0;

  vid_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .frame_vsync(frame_vsync),
    .frame_hsync(frame_hsync),
    .frame_de(frame_de),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .frame_start(frame_start),
    .line_start(line_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    int de_cnt, de_bad, pix_bad, hs_bad, hs_cnt, ls_cnt, vs_cnt, vs_first, fs_cnt, wait_cnt;
    rst = 1'b1;
    en  = 1'b1;
    adv(3);
    // 1: reset values (polarity 1 => inactive level 0)
    chk("rst_flags", {27'd0, frame_de, frame_hsync, frame_vsync, frame_start, line_start}, 32'd0);
    chk("rst_pix", {pix_y[15:0], pix_x[15:0]}, 32'd0);
    rst = 1'b0;
    adv(1);
    chk("first_flags", {29'd0, frame_de, frame_start, line_start}, 32'd7);
    chk("first_pix", {pix_y[15:0], pix_x[15:0]}, 32'd0);

    // 2/3: one full frame, index i maps to h=i%14, v=i/14
    de_cnt = 0; de_bad = 0; pix_bad = 0; hs_bad = 0; hs_cnt = 0;
    ls_cnt = 0; vs_cnt = 0; vs_first = -1; fs_cnt = 0;
    for (int i = 0; i < 112; i++) begin
      int hp, vp;
      logic exp_de;
      hp = i % 14;
      vp = i / 14;
      exp_de = (hp < 8) && (vp < 4);
      if (frame_de) de_cnt++;
      if (frame_de !== exp_de) de_bad++;
      if (frame_de && (pix_x != CNT_W'(hp) || pix_y != CNT_W'(vp))) pix_bad++;
      if (!frame_de && (pix_x != '0 || pix_y != '0)) pix_bad++;
      if (frame_hsync) hs_cnt++;
      if (frame_hsync !== (hp >= 10 && hp <= 12)) hs_bad++;
      if (line_start) ls_cnt++;
      if (frame_start) fs_cnt++;
      if (frame_vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = i;
      end
      adv(1);
    end
    chk("de_count", de_cnt, 32);
    chk("de_position", de_bad, 0);
    chk("pix_coords", pix_bad, 0);
    chk("hsync_count", hs_cnt, 24);
    chk("hsync_position", hs_bad, 0);
    chk("line_start_count", ls_cnt, 4);
    chk("frame_start_count", fs_cnt, 1);
    chk("vsync_count", vs_cnt, 28);
    chk("vsync_first", vs_first, 70);
    chk("frame2_start", {30'd0, frame_start, frame_de}, 32'd3);
    chk("frame2_pix", {pix_y[15:0], pix_x[15:0]}, 32'd0);

    // 4: freeze at pixel (3,2)
    adv(31);
    chk("pre_freeze_pix", {pix_y[15:0], pix_x[15:0]}, {16'd2, 16'd3});
    en = 1'b0;
    adv(5);
    chk("frozen_pix", {pix_y[15:0], pix_x[15:0]}, {16'd2, 16'd3});
    chk("frozen_de", frame_de, 1);
    en = 1'b1;
    adv(1);
    chk("resume_pix", {pix_y[15:0], pix_x[15:0]}, {16'd2, 16'd4});
    wait_cnt = 0;
    while (!frame_start && wait_cnt <= 200) begin
      adv(1);
      wait_cnt++;
    end
    chk("en_frame_period_rest", wait_cnt, 80);

    // frame_start high while frozen stays high
    en = 1'b0;
    adv(3);
    chk("fs_held_frozen", {30'd0, frame_start, line_start}, 32'd3);
    en = 1'b1;
    adv(1);
    chk("fs_after_freeze", {31'd0, frame_start}, 32'd0);
    chk("pix_after_freeze", {pix_y[15:0], pix_x[15:0]}, 32'd1);

    // 5: mid-frame reset at pixel (5,1)
    adv(18);
    chk("pre_rst_pix", {pix_y[15:0], pix_x[15:0]}, {16'd1, 16'd5});
    rst = 1'b1;
    adv(1);
    chk("midrst_flags", {27'd0, frame_de, frame_hsync, frame_vsync, frame_start, line_start}, 32'd0);
    chk("midrst_pix", {pix_y[15:0], pix_x[15:0]}, 32'd0);
    rst = 1'b0;
    adv(1);
    chk("post_rst_flags", {29'd0, frame_de, frame_start, line_start}, 32'd7);
    chk("post_rst_pix", {pix_y[15:0], pix_x[15:0]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
